// File: rtl/sr323_ctrl.sv
// Sequencer for an sn74ls323 used as a serial transceiver: parallel load over qio,
// NBITS shift clocks from sin, then read the shifted byte back off qio.
module sr323_ctrl #(
    parameter int NBITS    = 8,
    parameter bit DIR_LEFT = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] din,
    input  logic       dvalid,
    output logic       dready,
    input  logic       sin,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       busy,
    output logic       rs1,
    output logic       rs0,
    output logic       rg_n,
    output logic       rclr_n,
    output logic       rsr,
    output logic       rsl,
    inout  wire  [7:0] rq
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // valid never depends on ready, and data is held stable while valid is high.
    typedef enum logic [2:0] {
        CLRREG,
        IDLE,
        LOAD,
        SHIFT,
        SETTLE,
        CAPT,
        RVAL
    } state_t;

    localparam logic [3:0] CNT_LAST   = 4'(NBITS - 1);
    localparam logic [1:0] SHIFT_MODE = DIR_LEFT ? 2'b10 : 2'b01;

    state_t     state;
    state_t     state_nx;
    logic [7:0] tx;
    logic [3:0] cnt;
    logic       drive_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= CLRREG;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tx    <= 8'h00;
            cnt   <= 4'd0;
            rdata <= 8'h00;
        end else begin
            if (state == IDLE && dvalid) begin
                tx <= din;
            end
            if (state == LOAD) begin
                cnt <= 4'd0;
            end else if (state == SHIFT) begin
                cnt <= cnt + 4'd1;
            end
            // The '323 has been driving qio since SETTLE, so the bus is stable here.
            if (state == CAPT) begin
                rdata <= rq;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        dready     = 1'b0;
        rvalid     = 1'b0;
        rclr_n     = 1'b1;
        {rs1, rs0} = 2'b00;
        rg_n       = 1'b1;
        drive_q    = 1'b0;
        case (state)
            CLRREG: begin
                rclr_n   = 1'b0;
                state_nx = IDLE;
            end
            IDLE: begin
                dready = 1'b1;
                if (dvalid) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                {rs1, rs0} = 2'b11;
                drive_q    = 1'b1;
                state_nx   = SHIFT;
            end
            SHIFT: begin
                {rs1, rs0} = SHIFT_MODE;
                if (cnt == CNT_LAST) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                rg_n     = 1'b0;
                state_nx = CAPT;
            end
            CAPT: begin
                rg_n     = 1'b0;
                state_nx = RVAL;
            end
            RVAL: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = CLRREG;
        endcase
    end

    // Only LOAD drives qio, and the '323 outputs are disabled there, so the bus never contends.
    assign rq   = drive_q ? tx : 8'bz;
    assign busy = (state != IDLE);
    assign rsr  = sin;
    assign rsl  = sin;

endmodule
